// File: rtl/vec_data_mem_arbiter.sv
// Round-robin arbiter sharing one vector data memory port; bursts own the port until done or stalled out.
// Grant costs 1 cycle, read data returns 1 cycle after an accepted beat; non-owners wait, owner stalls time out.
module vec_data_mem_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int WIDTH         = 16,
  parameter int ADDR_SIZE     = 32,
  parameter int LEN_W         = 4,
  parameter int STALL_TIMEOUT = 15
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_write,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]     req_len,
  input  logic [NUM_REQ*WIDTH*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [WIDTH*32-1:0]          rsp_data,
  output logic [NUM_REQ-1:0]           abort,
  output logic [ADDR_SIZE-1:0]         mem_addr,
  output logic                         mem_write_en,
  output logic [WIDTH*32-1:0]          mem_wdata,
  input  logic [WIDTH*32-1:0]          mem_rdata
);
  localparam int REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DW      = WIDTH * 32;
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state;
  logic [REQ_W-1:0]     owner;
  logic [REQ_W-1:0]     last_grant;
  logic                 is_write;
  logic [ADDR_SIZE-1:0] base;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [LEN_W-1:0]     len;
  logic [LEN_W-1:0]     beat;
  logic [STALL_W-1:0]   stall_cnt;

  logic [REQ_W-1:0]     winner;
  logic                 any_valid;
  logic                 accept;
  logic [ADDR_SIZE-1:0] beat_addr;

  // Scan from farthest to nearest after last_grant so the nearest valid requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    winner    = last_grant;
    any_valid = |req_valid;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[idx]) winner = REQ_W'(idx);
    end
  end

  assign accept    = (state == BURST) && req_valid[owner];
  assign beat_addr = base + ADDR_SIZE'(beat);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[owner] = 1'b1;
  end

  assign mem_addr     = accept ? beat_addr : addr_q;
  assign mem_write_en = accept && is_write;
  assign mem_wdata    = req_wdata[int'(owner)*DW +: DW];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= REQ_W'(NUM_REQ - 1);
      is_write   <= 1'b0;
      base       <= '0;
      addr_q     <= '0;
      len        <= '0;
      beat       <= '0;
      stall_cnt  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      abort      <= '0;
    end else begin
      rsp_valid <= '0;
      abort     <= '0;
      if (accept) addr_q <= beat_addr;
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner      <= winner;
            last_grant <= winner;
            is_write   <= req_write[winner];
            base       <= req_addr[int'(winner)*ADDR_SIZE +: ADDR_SIZE];
            len        <= req_len[int'(winner)*LEN_W +: LEN_W];
            beat       <= '0;
            stall_cnt  <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            stall_cnt <= '0;
            beat      <= beat + 1'b1;
            if (!is_write) begin
              rsp_valid[owner] <= 1'b1;
              rsp_data         <= mem_rdata;
            end
            if (beat == len) state <= IDLE;
          end else if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
            // Remaining beats of the burst are dropped; the requester sees only the abort pulse.
            abort[owner] <= 1'b1;
            stall_cnt    <= '0;
            state        <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_data_mem_arbiter.sv
// Randomized bench for vec_data_mem_arbiter: per-requester burst drivers, a behavioural memory
// reference and a response scoreboard that checks every accepted beat and every returned word.
module tb_vec_data_mem_arbiter;
  localparam int NR = 2;
  localparam int AW = 32;
  localparam int LW = 4;
  localparam int TO = 15;
  localparam int DW = 16 * 32;

  logic              clock;
  logic              reset;
  logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid, abort;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*LW-1:0]  req_len;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_data, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_write_en;

  logic              d_valid [NR];
  logic              d_write [NR];
  logic [AW-1:0]     d_addr  [NR];
  logic [LW-1:0]     d_len   [NR];
  logic [DW-1:0]     d_wdata [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = d_valid[i];
      req_write[i]           = d_write[i];
      req_addr[i*AW +: AW]   = d_addr[i];
      req_len[i*LW +: LW]    = d_len[i];
      req_wdata[i*DW +: DW]  = d_wdata[i];
    end
  end

  vec_data_mem_arbiter #(.NUM_REQ(NR), .WIDTH(16), .ADDR_SIZE(AW), .LEN_W(LW), .STALL_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .abort(abort), .mem_addr(mem_addr),
    .mem_write_en(mem_write_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory behind the arbiter (256 words, aliased on low address bits) and its reference copy.
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clock) if (mem_write_en) mem[mem_addr[7:0]] = mem_wdata;

  typedef struct { int r; logic [DW-1:0] d; } rsp_t;
  rsp_t          rsp_q[$];
  int            grant_log[$];
  logic [AW-1:0] cur_base [NR];
  logic          cur_wr   [NR];
  int            beat_cnt [NR];
  logic [AW-1:0] last_addr;
  int            abort_hits;
  int            checks, errors;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor / scoreboard
  always @(negedge clock) begin
    if (reset) begin
      rsp_q.delete();
      grant_log.delete();
      last_addr = '0;
    end else begin
      if (rsp_valid != '0 || rsp_q.size() != 0) begin
        logic [NR-1:0] exp_v;
        exp_v = '0;
        if (rsp_q.size() != 0) exp_v[rsp_q[0].r] = 1'b1;
        check("rsp_valid", rsp_valid, exp_v);
        if (rsp_q.size() != 0) begin
          rsp_t e;
          e = rsp_q.pop_front();
          if (rsp_valid != '0) check("rsp_data", rsp_data, e.d);
        end
      end
      if (abort != '0) abort_hits++;
      if (req_ready != '0) begin
        check("ready_onehot", $onehot(req_ready), 1);
        check("ready_needs_valid", req_ready & ~req_valid, 0);
      end
      for (int r = 0; r < NR; r++) begin
        if (req_ready[r] && req_valid[r]) begin
          logic [AW-1:0] ea;
          ea = cur_base[r] + AW'(beat_cnt[r]);
          check("beat_addr", mem_addr, ea);
          check("beat_we", mem_write_en, cur_wr[r]);
          if (cur_wr[r]) begin
            check("beat_wdata", mem_wdata, d_wdata[r]);
            ref_mem[ea[7:0]] = d_wdata[r];
          end else begin
            rsp_q.push_back('{r, ref_mem[ea[7:0]]});
          end
          if (beat_cnt[r] == 0) grant_log.push_back(r);
          beat_cnt[r]++;
          last_addr = ea;
        end
      end
      if (req_ready == '0) begin
        check("idle_we", mem_write_en, 0);
        check("addr_hold", mem_addr, last_addr);
      end
    end
  end

  // One burst from requester r; first_wait = cycles from raising valid to first acceptance.
  task automatic burst(input int r, input logic wr, input logic [AW-1:0] base, input int len,
                       input bit stalls, output int first_wait);
    int waited;
    first_wait  = 0;
    cur_base[r] = base;
    cur_wr[r]   = wr;
    beat_cnt[r] = 0;
    d_write[r]  = wr;
    d_addr[r]   = base;
    d_len[r]    = LW'(len);
    for (int b = 0; b <= len; b++) begin
      d_wdata[r] = rnd_word();
      d_valid[r] = 1'b1;
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!req_ready[r] && waited < 400);
      if (!req_ready[r]) begin
        fail("beat_wait");
        d_valid[r] = 1'b0;
        return;
      end
      if (b == 0) first_wait = waited;
      @(posedge clock); #1;
      if (stalls && b < len && $urandom_range(3) == 0) begin
        d_valid[r] = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge clock);
        #1;
      end
    end
    d_valid[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < NR; i++) d_valid[i] = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  int w0, w1, n;
  logic [AW-1:0] b0;

  initial begin
    checks = 0; errors = 0; abort_hits = 0; last_addr = '0;
    reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      d_valid[i] = 1'b0; d_write[i] = 1'b0; d_addr[i] = '0; d_len[i] = '0; d_wdata[i] = '0;
      cur_base[i] = '0; cur_wr[i] = 1'b0; beat_cnt[i] = 0;
    end
    for (int i = 0; i < 256; i++) begin
      logic [DW-1:0] v;
      v = rnd_word();
      mem[i] = v;
      ref_mem[i] = v;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_abort", abort, 0);
    check("rst_we", mem_write_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_rsp_data", rsp_data, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Single read: grant cycle then beat
    burst(0, 1'b0, 32'h10, 0, 1'b0, w0);
    check("first_latency", w0, 2);
    repeat (3) @(posedge clock); #1;

    // Write burst from r1, then read back through r0
    burst(1, 1'b1, 32'h20, 3, 1'b0, w1);
    check("write_beats", beat_cnt[1], 4);
    repeat (2) @(posedge clock); #1;
    for (int i = 0; i < 4; i++) check("mem_written", mem[8'h20 + i], ref_mem[8'h20 + i]);
    burst(0, 1'b0, 32'h20, 3, 1'b0, w0);
    repeat (3) @(posedge clock); #1;

    // Address wrap
    burst(0, 1'b1, 32'hFFFF_FFFF, 1, 1'b0, w0);
    burst(1, 1'b0, 32'hFFFF_FFFF, 1, 1'b0, w1);
    repeat (3) @(posedge clock); #1;

    // Contention: strict alternation starting at r0
    do_reset();
    fork
      begin
        int wa;
        for (int k = 0; k < 4; k++) burst(0, 1'b0, $urandom, 0, 1'b0, wa);
      end
      begin
        int wb;
        for (int k = 0; k < 4; k++) burst(1, 1'b0, $urandom, 0, 1'b0, wb);
      end
    join
    repeat (2) @(posedge clock); #1;
    check("rr_count", grant_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) check("rr_order", grant_log[i], i % 2);

    // Stall timeout on r0 while r1 waits
    b0 = $urandom;
    cur_base[0] = b0; cur_wr[0] = 1'b0; beat_cnt[0] = 0;
    d_write[0] = 1'b0; d_addr[0] = b0; d_len[0] = 4'd3; d_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!req_ready[0] && n < 50);
    if (!req_ready[0]) fail("timeout_first_beat");
    @(posedge clock); #1;
    d_valid[0] = 1'b0;
    fork
      burst(1, 1'b1, $urandom, 0, 1'b0, w1);
      begin
        n = 0;
        do begin @(negedge clock); n++; end while (abort == '0 && n < 50);
        check("abort_delay", n, TO + 1);
        check("abort_vec", abort, 2'b01);
        @(negedge clock);
        check("abort_pulse", abort, 0);
      end
    join
    repeat (2) @(posedge clock); #1;
    check("r0_beats_before_abort", beat_cnt[0], 1);
    check("after_abort_grant", grant_log.size() > 0 ? grant_log[grant_log.size()-1] : -1, 1);
    check("abort_hits", abort_hits, 1);

    // Reset during the second beat of a 4-beat read
    b0 = $urandom;
    cur_base[0] = b0; cur_wr[0] = 1'b0; beat_cnt[0] = 0;
    d_write[0] = 1'b0; d_addr[0] = b0; d_len[0] = 4'd3; d_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!req_ready[0] && n < 50);
    if (!req_ready[0]) fail("rstmid_first_beat");
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    d_valid[0] = 1'b0;
    @(negedge clock);
    check("rstmid_rsp_valid", rsp_valid, 0);
    check("rstmid_rsp_data", rsp_data, 0);
    check("rstmid_ready", req_ready, 0);
    check("rstmid_abort", abort, 0);
    check("rstmid_we", mem_write_en, 0);
    check("rstmid_addr", mem_addr, 0);
    @(posedge clock); #1;
    fork
      burst(0, 1'b0, $urandom, 0, 1'b0, w0);
      burst(1, 1'b0, $urandom, 0, 1'b0, w1);
    join
    check("rstmid_first_owner", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    repeat (3) @(posedge clock); #1;

    // Randomized traffic with short owner stalls
    abort_hits = 0;
    fork
      begin
        int wa;
        for (int k = 0; k < 12; k++)
          burst(0, 1'($urandom_range(1)), $urandom, $urandom_range(15), 1'b1, wa);
      end
      begin
        int wb;
        for (int k = 0; k < 12; k++)
          burst(1, 1'($urandom_range(1)), $urandom, $urandom_range(15), 1'b1, wb);
      end
    join
    repeat (4) @(posedge clock); #1;
    check("rand_no_abort", abort_hits, 0);
    check("rsp_drained", rsp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
